pool1_ctrl: RTL and testbench

Sequencer for the first max-pooling layer of the LeNet datapath. Scans the 28×28 conv1 feature-map buffer (f2, six 16-bit channels packed per 96-bit word) in non-overlapping 2×2 windows and issues f2 read addresses. Drives `pool1_clr` to the six-lane pool execution array and writes the 14×14 pooled result into the f3 buffer. Sits between the conv1 stage, which fills f2, and the pool execution array plus the conv2 stage, which consumes f3.

---
 rtl/lenet_pkg.sv | 21 ++
 rtl/pool_win_addr_gen.sv | 89 ++++++++
 rtl/pool1_ctrl.sv | 104 ++++++++++
 tb/tb_pool1_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared constants, state encoding and address-width helpers for the LeNet layer sequencers.
`timescale 1ns/1ps
package lenet_pkg;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int POOL1_MAP_W = 28;
  localparam int POOL1_OUT_W = POOL1_MAP_W / 2;
  localparam int POOL1_RA_W  = addr_bits(POOL1_MAP_W * POOL1_MAP_W);
  localparam int POOL1_WA_W  = addr_bits(POOL1_OUT_W * POOL1_OUT_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_t;

endpackage

// File: rtl/pool_win_addr_gen.sv
// Walks non-overlapping 2x2 windows row by row and produces the f2 read address
// and f3 pixel index from running bases, so no multiplier is needed.
`timescale 1ns/1ps
module pool_win_addr_gen
  import lenet_pkg::*;
#(
  parameter int MAP_W = POOL1_MAP_W,
  parameter int OUT_W = MAP_W / 2,
  parameter int RA_W  = POOL1_RA_W,
  parameter int WA_W  = POOL1_WA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            step,
  output logic [RA_W-1:0] raddr,
  output logic [WA_W-1:0] waddr,
  output logic [1:0]      phase,
  output logic            last
);

  localparam int CW = addr_bits(OUT_W);

  logic [CW-1:0]   col;
  logic [CW-1:0]   row;
  logic [1:0]      p;
  logic [RA_W-1:0] win_base;
  logic [WA_W-1:0] pix;
  logic [RA_W-1:0] offset;
  logic            col_end;
  logic            row_end;

  assign col_end = (col == CW'(OUT_W - 1));
  assign row_end = (row == CW'(OUT_W - 1));
  assign last    = (p == 2'd3) && col_end && row_end;

  // Advance phase every read; at the end of a window move to the next window,
  // jumping down two map rows when the column wraps, and fold back to zero after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      p        <= '0;
      win_base <= '0;
      pix      <= '0;
    end else if (clear) begin
      col      <= '0;
      row      <= '0;
      p        <= '0;
      win_base <= '0;
      pix      <= '0;
    end else if (step) begin
      p <= p + 2'd1;
      if (p == 2'd3) begin
        if (last) begin
          col      <= '0;
          row      <= '0;
          win_base <= '0;
          pix      <= '0;
        end else if (col_end) begin
          col      <= '0;
          row      <= row + CW'(1);
          win_base <= win_base + RA_W'(MAP_W + 2);
          pix      <= pix + WA_W'(1);
        end else begin
          col      <= col + CW'(1);
          win_base <= win_base + RA_W'(2);
          pix      <= pix + WA_W'(1);
        end
      end
    end
  end

  // Offset of the current window element: top-left, top-right, bottom-left, bottom-right.
  always_comb begin
    offset = '0;
    case (p)
      2'd0:    offset = '0;
      2'd1:    offset = RA_W'(1);
      2'd2:    offset = RA_W'(MAP_W);
      default: offset = RA_W'(MAP_W + 1);
    endcase
  end

  assign raddr = win_base + offset;
  assign waddr = pix;
  assign phase = p;

endmodule

// File: rtl/pool1_ctrl.sv
// Pool1 sequencer: FSM issuing f2 reads for every 2x2 window, plus the delay
// pipeline that lines up the clear marker and f3 writes with RAM and pool latency.
`timescale 1ns/1ps
module pool1_ctrl
  import lenet_pkg::*;
#(
  parameter int MAP_W = POOL1_MAP_W,
  parameter int OUT_W = MAP_W / 2,
  parameter int RA_W  = POOL1_RA_W,
  parameter int WA_W  = POOL1_WA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pool1_start,
  output logic            pool1_busy,
  output logic            pool1_done,
  output logic            f2_ren,
  output logic [RA_W-1:0] f2_raddr,
  output logic            pool1_clr,
  output logic            f3_wen,
  output logic [WA_W-1:0] f3_waddr
);

  pool_state_t     state_q;
  pool_state_t     state_d;
  logic            gen_clear;
  logic            gen_step;
  logic            gen_last;
  logic [1:0]      gen_phase;
  logic [RA_W-1:0] gen_raddr;
  logic [WA_W-1:0] gen_waddr;
  logic            clr_d1;
  logic            wen_d1;
  logic            wen_d2;
  logic [WA_W-1:0] waddr_d1;
  logic [WA_W-1:0] waddr_d2;

  assign gen_clear = (state_q == ST_IDLE);
  assign gen_step  = (state_q == ST_RUN);

  pool_win_addr_gen #(
    .MAP_W (MAP_W),
    .OUT_W (OUT_W),
    .RA_W  (RA_W),
    .WA_W  (WA_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (gen_clear),
    .step  (gen_step),
    .raddr (gen_raddr),
    .waddr (gen_waddr),
    .phase (gen_phase),
    .last  (gen_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start only from idle, drain until the final write has gone out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pool1_start) state_d = ST_RUN;
      ST_RUN:   if (gen_last)    state_d = ST_DRAIN;
      ST_DRAIN: if (wen_d2)      state_d = ST_DONE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the read address is held at zero outside the read phase.
  always_comb begin
    pool1_busy = (state_q != ST_IDLE);
    pool1_done = (state_q == ST_DONE);
    f2_ren     = (state_q == ST_RUN);
    f2_raddr   = (state_q == ST_RUN) ? gen_raddr : '0;
  end

  // Clear marker trails the first read by one cycle (RAM latency); the write trails
  // the last read by two (RAM latency plus the pool register), with its pixel index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_d1   <= 1'b0;
      wen_d1   <= 1'b0;
      wen_d2   <= 1'b0;
      waddr_d1 <= '0;
      waddr_d2 <= '0;
    end else begin
      clr_d1   <= gen_step && (gen_phase == 2'd0);
      wen_d1   <= gen_step && (gen_phase == 2'd3);
      wen_d2   <= wen_d1;
      waddr_d1 <= gen_waddr;
      waddr_d2 <= waddr_d1;
    end
  end

  assign pool1_clr = clr_d1;
  assign f3_wen    = wen_d2;
  assign f3_waddr  = waddr_d2;

endmodule

// File: tb/tb_pool1_ctrl.sv
// Randomized scoreboard bench for pool1_ctrl with a behavioural f2 RAM and pool array.
`timescale 1ns/1ps
module tb_pool1_ctrl;

  localparam int MAP_W   = 28;
  localparam int OUT_W   = 14;
  localparam int RA_W    = 10;
  localparam int WA_W    = 8;
  localparam int NWIN    = OUT_W * OUT_W;
  localparam int RUN_LEN = 4 * NWIN + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pool1_start = 1'b0;
  logic            pool1_busy;
  logic            pool1_done;
  logic            f2_ren;
  logic [RA_W-1:0] f2_raddr;
  logic            pool1_clr;
  logic            f3_wen;
  logic [WA_W-1:0] f3_waddr;

  pool1_ctrl #(
    .MAP_W (MAP_W),
    .OUT_W (OUT_W),
    .RA_W  (RA_W),
    .WA_W  (WA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pool1_start (pool1_start),
    .pool1_busy  (pool1_busy),
    .pool1_done  (pool1_done),
    .f2_ren      (f2_ren),
    .f2_raddr    (f2_raddr),
    .pool1_clr   (pool1_clr),
    .f3_wen      (f3_wen),
    .f3_waddr    (f3_waddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int cyc;
  } rd_exp_t;

  typedef struct {
    int          addr;
    logic [95:0] data;
    int          cyc;
  } wr_exp_t;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [95:0] ram [0:MAP_W*MAP_W-1];
  logic [95:0] rdata;
  logic [95:0] acc;
  logic        ren_s = 1'b0;
  logic        clr_s = 1'b0;
  logic [RA_W-1:0] raddr_s = '0;
  logic        prev_busy = 1'b0;
  int          busy_rise = 0;
  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  int          clr_q[$];
  int          done_q[$];

  // Free-running cycle counter used to timestamp every observed event.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] lane_max(input logic [95:0] a, input logic [95:0] b);
    logic [95:0] m;
    for (int i = 0; i < 6; i++)
      m[i*16 +: 16] = (a[i*16 +: 16] > b[i*16 +: 16]) ? a[i*16 +: 16] : b[i*16 +: 16];
    return m;
  endfunction

  function automatic logic [95:0] window_max(input int base);
    logic [95:0] m;
    m = lane_max(ram[base], ram[base + 1]);
    m = lane_max(m, ram[base + MAP_W]);
    m = lane_max(m, ram[base + MAP_W + 1]);
    return m;
  endfunction

  function automatic logic [22:0] out_vec();
    return {pool1_busy, pool1_done, f2_ren, pool1_clr, f3_wen, f2_raddr, f3_waddr};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name, input string msg);
    tests++;
    fails++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Behavioural environment: synchronous f2 RAM and the six-lane max-pool register.
  always @(negedge clk) begin
    ren_s   <= f2_ren;
    raddr_s <= f2_raddr;
    clr_s   <= pool1_clr;
  end

  always @(posedge clk) begin
    if (ren_s) rdata <= ram[raddr_s];
    if (clr_s) acc <= rdata;
    else       acc <= lane_max(acc, rdata);
  end

  // Expected events of one full layer pass whose start is sampled in cycle s.
  task automatic push_run(input int s);
    int r;
    int c;
    int base;
    int addrs[4];
    for (int k = 0; k < NWIN; k++) begin
      r = k / OUT_W;
      c = k % OUT_W;
      base = 2 * r * MAP_W + 2 * c;
      addrs[0] = base;
      addrs[1] = base + 1;
      addrs[2] = base + MAP_W;
      addrs[3] = base + MAP_W + 1;
      for (int p = 0; p < 4; p++) rd_q.push_back('{addr: addrs[p], cyc: s + 1 + 4 * k + p});
      clr_q.push_back(s + 2 + 4 * k);
      wr_q.push_back('{addr: k, data: window_max(base), cyc: s + 6 + 4 * k});
    end
    done_q.push_back(s + RUN_LEN);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, clear, write or done.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy <= 1'b0;
    end else begin
      prev_busy <= pool1_busy;
      if (pool1_busy && !prev_busy) busy_rise <= cyc;
      if (f2_ren) begin
        if (rd_q.size() == 0) report_fail("extra_read", $sformatf("read of addr %0d, none expected", f2_raddr));
        else begin
          check_output("f2_raddr", 128'(f2_raddr), 128'(rd_q[0].addr));
          check_output("f2_read_cycle", 128'(cyc), 128'(rd_q[0].cyc));
          rd_q.delete(0);
        end
      end
      if (pool1_clr) begin
        if (clr_q.size() == 0) report_fail("extra_clr", "pool1_clr high, none expected");
        else begin
          check_output("clr_cycle", 128'(cyc), 128'(clr_q[0]));
          clr_q.delete(0);
        end
      end
      if (f3_wen) begin
        if (wr_q.size() == 0) report_fail("extra_write", $sformatf("write to %0d, none expected", f3_waddr));
        else begin
          check_output("f3_waddr", 128'(f3_waddr), 128'(wr_q[0].addr));
          check_output("f3_wdata", 128'(acc), 128'(wr_q[0].data));
          check_output("f3_write_cycle", 128'(cyc), 128'(wr_q[0].cyc));
          wr_q.delete(0);
        end
      end
      if (pool1_done) begin
        if (done_q.size() == 0) report_fail("extra_done", "pool1_done high, none expected");
        else begin
          check_output("done_cycle", 128'(cyc), 128'(done_q[0]));
          check_output("busy_at_done", 128'(pool1_busy), 128'(1));
          check_output("busy_width", 128'(cyc - busy_rise + 1), 128'(RUN_LEN));
          done_q.delete(0);
        end
      end
    end
  end

  // One layer pass: optional spurious start mid-run, optional start on the done
  // cycle, optional asynchronous reset at a given cycle after start.
  task automatic apply_stimulus(input bit spurious, input bit coincide, input int reset_at);
    int  s;
    int  spur_at;
    bit  seen_done;
    @(negedge clk);
    pool1_start = 1'b1;
    s = cyc;
    push_run(s);
    spur_at = spurious ? int'($urandom_range(2, RUN_LEN - 1)) : -1;
    @(negedge clk);
    pool1_start = 1'b0;
    seen_done = 1'b0;
    while (!seen_done) begin
      if (cyc - s > RUN_LEN + 20) begin
        report_fail("done_timeout", "pool1_done never seen");
        break;
      end
      if (reset_at > 0 && cyc - s == reset_at - 1) begin
        @(posedge clk);
        #1;
        check_output("busy_before_reset", 128'(pool1_busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check_output("reset_async", 128'(out_vec()), 128'(0));
        rd_q.delete();
        clr_q.delete();
        wr_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      pool1_start = (cyc - s == spur_at);
      if (pool1_done) begin
        seen_done = 1'b1;
        pool1_start = coincide;
      end
      @(negedge clk);
    end
    pool1_start = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < MAP_W * MAP_W; a++)
      for (int i = 0; i < 6; i++) ram[a][i*16 +: 16] = 16'(a + i);
  endtask

  task automatic fill_random();
    for (int a = 0; a < MAP_W * MAP_W; a++) ram[a] = {$urandom, $urandom, $urandom};
  endtask

  task automatic check_drained(input string name);
    repeat (4) @(negedge clk);
    check_output(name, 128'(rd_q.size() + clr_q.size() + wr_q.size() + done_q.size()), 128'(0));
  endtask

  // Test sequence: reset, idle, ramp run with stray starts, back-to-back random run,
  // reset mid-run, and a clean run afterwards.
  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_values", 128'(out_vec()), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("idle_outputs", 128'(out_vec()), 128'(0));
    end

    fill_ramp();
    apply_stimulus(1'b1, 1'b1, 0);
    fill_random();
    apply_stimulus(1'b1, 1'b0, 0);
    check_drained("queues_drained_ab");

    fill_random();
    repeat (int'($urandom_range(1, 5))) @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 300);
    repeat (int'($urandom_range(2, 6))) @(negedge clk);
    check_output("idle_after_reset", 128'(out_vec()), 128'(0));
    fill_random();
    apply_stimulus(1'b1, 1'b0, 0);
    check_drained("queues_drained_d");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
